// File: rtl/miner_pkg.sv
// Shared definitions for the nonce collection path: default widths, send-FSM states, clog2.
// No logic, no latency, no backpressure.
package miner_pkg;

    localparam int NONCE_W_DEFAULT = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO with extra-MSB pointers; read data is combinational from the head entry.
// Push is ignored when full, pop is ignored when empty; simultaneous push/pop both proceed.
module nonce_fifo
    import miner_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign level_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/nonce_collector.sv
// Collects golden nonces from CORES cores (sync + edge detect + round-robin), queues them, sends one per handshake.
// Ticket rise to FIFO write is 3 clk; a full FIFO holds requests in pending[]; tx_busy stalls the send FSM.
module nonce_collector
    import miner_pkg::*;
#(
    parameter  int CORES      = 4,
    parameter  int NONCE_W    = NONCE_W_DEFAULT,
    parameter  int FIFO_DEPTH = 8,
    parameter  int BUSY_WAIT  = 15,
    localparam int IW         = clog2(CORES) + 1,
    localparam int LW         = clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CORES-1:0]         core_ticket,
    input  logic [CORES*NONCE_W-1:0] core_nonce,
    input  logic                     tx_busy,
    output logic                     tx_ready,
    output logic [NONCE_W-1:0]       tx_word,
    output logic [IW-1:0]            tx_core,
    output logic                     new_nonce,
    output logic [LW-1:0]            fifo_level,
    output logic [7:0]               drop_count
);

    localparam int CW = clog2(BUSY_WAIT + 1);

    logic [CORES-1:0]      sync1_q, sync2_q, sync3_q;
    logic [CORES-1:0]      pending_q, pending_d;
    logic [CORES-1:0]      rise, drop, eff_pending, grant_oh;
    logic                  grant_vld;
    logic [IW-1:0]         grant_idx;
    logic [IW-1:0]         last_q, last_d;
    logic [NONCE_W-1:0]    grant_nonce;
    logic                  new_nonce_q;
    logic [7:0]            drop_q, drop_d;

    logic                  fifo_full, fifo_empty, pop;
    logic [IW+NONCE_W-1:0] fifo_rdata;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         wait_q, wait_d;
    logic                  tx_ready_q, tx_ready_d;
    logic [NONCE_W-1:0]    tx_word_q;
    logic [IW-1:0]         tx_core_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= core_ticket;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise        = sync2_q & ~sync3_q;
    assign drop        = rise & pending_q;
    // Fresh edges are arbitrated in the same cycle so an idle core reaches the FIFO in 3 clk.
    assign eff_pending = pending_q | rise;

    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        for (int k = 1; k <= CORES; k++) begin
            idx = int'(last_q) + k;
            if (idx >= CORES) idx = idx - CORES;
            if (!grant_vld && !fifo_full && eff_pending[idx]) begin
                grant_vld     = 1'b1;
                grant_idx     = IW'(idx);
                grant_oh[idx] = 1'b1;
            end
        end
    end

    assign grant_nonce = core_nonce[int'(grant_idx)*NONCE_W +: NONCE_W];
    assign pending_d   = eff_pending & ~grant_oh;
    assign last_d      = grant_vld ? grant_idx : last_q;
    assign drop_d      = (|drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            last_q      <= IW'(CORES - 1);
            new_nonce_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            pending_q   <= pending_d;
            last_q      <= last_d;
            new_nonce_q <= grant_vld;
            drop_q      <= drop_d;
        end
    end

    nonce_fifo #(
        .WIDTH (IW + NONCE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (grant_vld),
        .wdata_i ({grant_idx, grant_nonce}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        pop        = 1'b0;
        tx_ready_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    pop        = 1'b1;
                    tx_ready_d = 1'b1;
                    wait_d     = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                // A serial_core that never raises busy must not wedge the queue.
                if (tx_busy) begin
                    state_d = ST_DRAIN;
                end else if (wait_q == CW'(BUSY_WAIT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            tx_ready_q <= 1'b0;
            tx_word_q  <= '0;
            tx_core_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            tx_ready_q <= tx_ready_d;
            if (pop) begin
                tx_word_q <= fifo_rdata[NONCE_W-1:0];
                tx_core_q <= fifo_rdata[IW+NONCE_W-1:NONCE_W];
            end
        end
    end

    assign tx_ready   = tx_ready_q;
    assign tx_word    = tx_word_q;
    assign tx_core    = tx_core_q;
    assign new_nonce  = new_nonce_q;
    assign drop_count = drop_q;

endmodule
